// File: rtl/mem_responder.sv
// Single-outstanding load/store responder over a 64-bit-word RAM with a fixed wait latency.
// Response is held in RESP until rsp_ready; req_ready is high only in IDLE.
module mem_responder #(
  parameter int DEPTH_LOG2 = 9,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic [63:0] rdata_q;
  logic        error_q;

  logic [63:0] mem [DEPTH];

  logic                  enter_resp;
  logic                  acc_write;
  logic [63:0]           acc_addr;
  logic [63:0]           acc_wdata;
  logic [7:0]            acc_wstrb;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;

  // With LATENCY=0 the access happens on the accept edge, so use the live request.
  always_comb begin
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
  end

  assign acc_idx = acc_addr[3+DEPTH_LOG2-1:3];
  assign acc_err = (acc_addr[2:0] != 3'd0) || (acc_addr[63:3+DEPTH_LOG2] != '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      wstrb_q <= 8'd0;
      rdata_q <= 64'd0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (enter_resp) begin
        error_q <= acc_err;
        rdata_q <= (acc_write || acc_err) ? 64'd0 : mem[acc_idx];
      end else if (state_q == RESP && rsp_ready) begin
        error_q <= 1'b0;
        rdata_q <= 64'd0;
      end
    end
  end

  // RAM is not reset; a reset drops the FSM out of WAIT before any write can occur.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_write && !acc_err) begin
      for (int b = 0; b < 8; b++) begin
        if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed vector bench for mem_responder (DEPTH_LOG2=9, LATENCY=2).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  int total = 0;
  int passed = 0;

  mem_responder #(.DEPTH_LOG2(9), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] exp_rdata;
    logic        exp_error;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    else passed++;
  endtask

  // Drives a request at a negedge and returns once the accepting edge has passed.
  task automatic send_req(input vec_t v, input string name);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_wstrb = v.wstrb;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({name, "_accept_timeout"}, 64'(n), 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~v.write;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    req_wstrb = ~v.wstrb;
  endtask

  // Returns the number of edges after the accept edge before rsp_valid is seen.
  task automatic wait_rsp(input string name, output int n);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({name, "_rsp_timeout"}, 64'(n), 64'd0);
  endtask

  task automatic do_txn(input vec_t v, input string name);
    int n;
    send_req(v, name);
    wait_rsp(name, n);
    chk({name, "_latency"}, 64'(n), 64'd2);
    chk({name, "_rdata"}, rsp_rdata, v.exp_rdata);
    chk({name, "_error"}, 64'(rsp_error), 64'(v.exp_error));
  endtask

  function automatic vec_t mk(input logic w, input logic [63:0] a, input logic [63:0] d,
                              input logic [7:0] s, input logic [63:0] er, input logic ee);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.wstrb = s; v.exp_rdata = er; v.exp_error = ee;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    logic [63:0] held;

    tbl[0]  = mk(1, 64'h10,  64'h1122334455667788, 8'hFF, 64'h0, 0);
    tbl[1]  = mk(0, 64'h10,  64'h0,                8'h00, 64'h1122334455667788, 0);
    tbl[2]  = mk(1, 64'h10,  64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 0);
    tbl[3]  = mk(0, 64'h10,  64'h0,                8'hFF, 64'h11223344AAAAAAAA, 0);
    tbl[4]  = mk(0, 64'h13,  64'h0,                8'h00, 64'h0, 1);
    tbl[5]  = mk(0, 64'h1000, 64'h0,               8'h00, 64'h0, 1);
    tbl[6]  = mk(1, 64'h13,  64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1);
    tbl[7]  = mk(0, 64'h10,  64'h0,                8'h00, 64'h11223344AAAAAAAA, 0);
    tbl[8]  = mk(1, 64'h20,  64'h0,                8'hFF, 64'h0, 0);
    tbl[9]  = mk(1, 64'h20,  64'h0123456789ABCDEF, 8'h81, 64'h0, 0);
    tbl[10] = mk(0, 64'h20,  64'h0,                8'h00, 64'h01000000000000EF, 0);
    tbl[11] = mk(1, 64'h20,  64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 0);
    tbl[12] = mk(0, 64'h20,  64'h0,                8'h00, 64'h01000000000000EF, 0);
    tbl[13] = mk(0, 64'h8000000000000000, 64'h0,  8'h00, 64'h0, 1);
    tbl[14] = mk(1, 64'h18,  64'hDEADBEEF00000000, 8'hFF, 64'h0, 0);
    tbl[15] = mk(0, 64'h18,  64'h0,                8'h00, 64'hDEADBEEF00000000, 0);
    tbl[16] = mk(1, 64'hFF8, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 64'h0, 0);
    tbl[17] = mk(0, 64'hFF8, 64'h0,                8'h00, 64'h5A5A5A5A5A5A5A5A, 0);

    rst_n = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 64'h0; req_wdata = 64'h0; req_wstrb = 8'h0;
    rsp_ready = 1'b1;

    // Asynchronous reset between edges.
    #7 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    #20 rst_n = 1'b1;

    for (int i = 0; i < 18; i++) do_txn(tbl[i], $sformatf("vec%0d", i));

    // Response stall with rsp_ready low; intervening request must be ignored.
    @(negedge clk);
    rsp_ready = 1'b0;
    send_req(tbl[3], "stall");
    wait_rsp("stall", n);
    held = rsp_rdata;
    chk("stall_rdata", held, 64'h11223344AAAAAAAA);
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10;
      req_wdata = 64'h0; req_wstrb = 8'hFF;
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), 64'(rsp_valid), 64'd1);
      chk($sformatf("stall%0d_rdata", c), rsp_rdata, held);
      chk($sformatf("stall%0d_req_ready", c), 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 64'(rsp_valid), 64'd0);
    chk("stall_release_rdata", rsp_rdata, 64'd0);
    chk("stall_release_req_ready", 64'(req_ready), 64'd1);
    do_txn(tbl[3], "stall_ignored_store");

    // Reset during WAIT drops a pending store.
    v = mk(1, 64'h18, 64'h1111111111111111, 8'hFF, 64'h0, 0);
    send_req(v, "rstwait");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstwait_req_ready", 64'(req_ready), 64'd1);
    chk("rstwait_rsp_valid", 64'(rsp_valid), 64'd0);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("rstwait_norsp%0d", c), 64'(rsp_valid), 64'd0);
    end
    do_txn(tbl[15], "rstwait_load");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
